// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU code constants, sequencer state encodings and op-class helpers.
package muldiv_sequencer_pkg;

  localparam logic [3:0] ALU_SRL  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_MUL  = 4'd7;
  localparam logic [3:0] ALU_MULH = 4'd8;
  localparam logic [3:0] ALU_DIV  = 4'd9;
  localparam logic [3:0] ALU_REM  = 4'd10;
  localparam logic [3:0] ALU_SUB  = 4'd11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic is_m_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration of shift-add multiply or restoring divide.
// Multiply layout: acc = {partial_hi, multiplier_remaining}, shifts right.
// Divide layout:   acc = {remainder, dividend/quotient}, shifts left.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  // Compute both candidate updates and pick by op class.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, operand};
    if (is_div) begin
      if (!div_diff[XLEN]) begin
        acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MULH/DIV/REM sequencer: magnitude iteration, then sign
// application and RISC-V corner-case overrides in a single fixup cycle.
//
//  state  | meaning
//  IDLE   | waiting for start with an M-extension code
//  CALC   | XLEN unsigned iterations, one per cycle
//  FIXUP  | apply signs / corner cases, write result
//  DONE   | done pulse, result valid
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   abs_a_q, abs_a_d;
  logic [XLEN-1:0]   abs_b_q, abs_b_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] step_acc;
  logic [XLEN-1:0]   abs_a_in, abs_b_in;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo, rem;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fix_value;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .operand  (is_div_op(op_q) ? abs_b_q : abs_a_q),
    .is_div   (is_div_op(op_q)),
    .acc_next (step_acc)
  );

  // Signed result selection with divide corner-case overrides.
  always_comb begin
    abs_a_in    = op_a[XLEN-1] ? (~op_a + 1'b1) : op_a;
    abs_b_in    = op_b[XLEN-1] ? (~op_b + 1'b1) : op_b;
    prod_signed = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
    quo         = acc_q[XLEN-1:0];
    rem         = acc_q[2*XLEN-1:XLEN];
    div_zero    = (abs_b_q == '0);
    div_ovf     = sign_a_q && (abs_a_q == MIN_VAL) && sign_b_q && (abs_b_q == XLEN'(1));
    fix_value   = '0;
    case (op_q)
      ALU_MUL:  fix_value = prod_signed[XLEN-1:0];
      ALU_MULH: fix_value = prod_signed[2*XLEN-1:XLEN];
      ALU_DIV: begin
        if (div_zero)     fix_value = '1;
        else if (div_ovf) fix_value = MIN_VAL;
        else              fix_value = (sign_a_q ^ sign_b_q) ? (~quo + 1'b1) : quo;
      end
      ALU_REM: begin
        if (div_zero)     fix_value = sign_a_q ? (~abs_a_q + 1'b1) : abs_a_q;
        else if (div_ovf) fix_value = '0;
        else              fix_value = sign_a_q ? (~rem + 1'b1) : rem;
      end
      default: fix_value = '0;
    endcase
  end

  // Next-state, capture, iteration and flush abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    abs_a_d  = abs_a_q;
    abs_b_d  = abs_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush && is_m_op(alu_op)) begin
          state_d  = ST_CALC;
          op_d     = alu_op;
          abs_a_d  = abs_a_in;
          abs_b_d  = abs_b_in;
          sign_a_d = op_a[XLEN-1];
          sign_b_d = op_b[XLEN-1];
          // High half cleared; low half seeded with the value that gets shifted out.
          acc_d    = {{XLEN{1'b0}}, is_div_op(alu_op) ? abs_a_in : abs_b_in};
          cnt_d    = '0;
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        if (cnt_q == LAST_CNT) state_d = ST_FIXUP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_FIXUP: begin
        result_d = fix_value;
        state_d  = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      abs_a_q  <= '0;
      abs_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      abs_a_q  <= abs_a_d;
      abs_b_q  <= abs_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against a signed-arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .alu_op (alu_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p;
    case (op)
      4'd7: begin p = sa * sb; return p[31:0]; end
      4'd8: begin p = sa * sb; return p[63:32]; end
      4'd9: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb;
        return p[31:0];
      end
      4'd10: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  // Start an op from IDLE; lat = edges after the accepting edge until done is seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    @(posedge clk); #1;
    start = 1'b1; alu_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   lat;
    logic bok;
    run_op(op, a, b, lat, bok);
    check({tag, "_res"}, result, ref_model(op, a, b));
    check({tag, "_lat"}, 32'(lat), 32'd33);
    check({tag, "_busy"}, {31'b0, bok}, 32'd1);
  endtask

  task automatic watch_no_done(input int cycles, output logic seen_done, output logic seen_busy);
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
  endtask

  initial begin
    int          lat;
    logic        bok;
    logic        sd;
    logic        sb;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] prior;

    reset = 1'b1; start = 1'b0; flush = 1'b0; alu_op = 4'd0; op_a = '0; op_b = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic multiply with latency and busy coverage, then the done pulse must end.
    op_check("mul_7x-3", 4'd7, 32'd7, 32'hFFFFFFFD);
    check("mul_7x-3_abs", result, 32'hFFFFFFEB);
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("idle_after_done", {31'b0, busy}, 32'd0);

    op_check("mulh_min_min", 4'd8, 32'h80000000, 32'h80000000);
    check("mulh_min_min_abs", result, 32'h40000000);
    op_check("mulh_m1_1", 4'd8, 32'hFFFFFFFF, 32'd1);
    op_check("div_m7_2", 4'd9, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2_abs", result, 32'hFFFFFFFD);
    op_check("rem_m7_2", 4'd10, 32'hFFFFFFF9, 32'd2);
    op_check("rem_7_m2", 4'd10, 32'd7, 32'hFFFFFFFE);
    op_check("div_5_0", 4'd9, 32'd5, 32'd0);
    op_check("rem_5_0", 4'd10, 32'd5, 32'd0);
    op_check("rem_m5_0", 4'd10, 32'hFFFFFFFB, 32'd0);
    op_check("div_ovf", 4'd9, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_abs", result, 32'h80000000);
    op_check("rem_ovf", 4'd10, 32'h80000000, 32'hFFFFFFFF);

    // Starts with new operands during CALC must be ignored.
    @(posedge clk); #1;
    start = 1'b1; alu_op = 4'd7; op_a = 32'd123; op_b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; alu_op = 4'd9; op_a = 32'd99; op_b = 32'd3;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
    end
    check("ignore_start_done", {31'b0, done}, 32'd1);
    prior = ref_model(4'd7, 32'd123, 32'd456);
    check("ignore_start_res", result, prior);

    // Flush at cycle 10 of a divide: abort, no done, result held.
    @(posedge clk); #1;
    start = 1'b1; alu_op = 4'd9; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    watch_no_done(40, sd, sb);
    check("flush_no_done", {31'b0, sd}, 32'd0);
    check("flush_result_held", result, prior);

    // Flush and start together in IDLE: nothing accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; alu_op = 4'd7; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);

    // Non-M code is not accepted.
    @(posedge clk); #1;
    start = 1'b1; alu_op = 4'd2; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    watch_no_done(40, sd, sb);
    check("add_no_busy", {31'b0, sb}, 32'd0);
    check("add_no_done", {31'b0, sd}, 32'd0);
    check("add_result_held", result, prior);

    // Reset mid-CALC: outputs clear asynchronously, no done afterwards.
    @(posedge clk); #1;
    start = 1'b1; alu_op = 4'd7; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    watch_no_done(40, sd, sb);
    check("midrst_no_done", {31'b0, sd}, 32'd0);

    // Back-to-back: second start issued in the first IDLE cycle after done.
    run_op(4'd7, 32'hFFFFFF00, 32'd77, lat, bok);
    check("b2b_mul_res", result, ref_model(4'd7, 32'hFFFFFF00, 32'd77));
    check("b2b_mul_lat", 32'(lat), 32'd33);
    run_op(4'd9, 32'd100000, 32'hFFFFFFF3, lat, bok);
    check("b2b_div_res", result, ref_model(4'd9, 32'd100000, 32'hFFFFFFF3));
    check("b2b_div_lat", 32'(lat), 32'd33);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'(7 + $urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, lat, bok);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), result, ref_model(rop, ra, rb));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
